oh_encode_pipe: RTL and testbench

Registered, multi-channel one-hot-to-binary encoder with a valid/ready handshake and input-legality checking. Each beat carries `NumCh` independent one-hot vectors. Each vector is encoded to a binary index in either strict one-hot mode or lowest-set-bit priority mode. The block flags zero and multi-hot lanes and keeps a saturating error counter. It sits between arbiters/grant vectors and index-consuming logic (mux selects, FIFO pointers), where a one-cycle registered boundary is needed.

---
 rtl/oh_pkg.sv | 13 +
 rtl/oh_encode_lane.sv | 41 ++++
 rtl/oh_encode_pipe.sv | 83 ++++++++
 tb/tb_oh_encode_pipe.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/oh_pkg.sv
// Shared types and width helper for the one-hot encoder pipeline.
package oh_pkg;

    typedef enum logic {
        OH_STRICT   = 1'b0,
        OH_PRIORITY = 1'b1
    } oh_mode_e;

    function automatic int oh_idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/oh_encode_lane.sv
// Combinational one-hot to binary encoder for a single lane, with zero/multi-hot flags.
module oh_encode_lane
    import oh_pkg::*;
#(
    parameter int InputWidth   = 8,
    parameter int PriorityMode = 0,
    localparam int OutputWidth = oh_idx_width(InputWidth)
) (
    input  logic [InputWidth-1:0]  oh,
    output logic [OutputWidth-1:0] idx,
    output logic                   zero,
    output logic                   multi
);

    localparam logic [InputWidth-1:0] One = InputWidth'(1);
    localparam bit IsPrio = (PriorityMode == int'(OH_PRIORITY));

    logic [OutputWidth-1:0] idx_v;
    logic                   found;

    // Strict mode ORs every set index; priority mode keeps the first (lowest) one.
    always_comb begin
        idx_v = '0;
        found = 1'b0;
        for (int i = 0; i < InputWidth; i++) begin
            if (oh[i]) begin
                if (IsPrio) begin
                    if (!found) idx_v = OutputWidth'(i);
                end else begin
                    idx_v = idx_v | OutputWidth'(i);
                end
                found = 1'b1;
            end
        end
    end

    assign idx   = idx_v;
    assign zero  = ~|oh;
    assign multi = |(oh & (oh - One));

endmodule

// File: rtl/oh_encode_pipe.sv
// Registered multi-lane one-hot encoder stage with valid/ready handshake and
// a saturating count of beats that carried illegal lanes.
module oh_encode_pipe
    import oh_pkg::*;
#(
    parameter int InputWidth   = 8,
    parameter int NumCh        = 1,
    parameter int PriorityMode = 0,
    parameter int ErrCntWidth  = 8,
    localparam int OutputWidth = oh_idx_width(InputWidth)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [NumCh*InputWidth-1:0]  oh_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [NumCh*OutputWidth-1:0] idx_o,
    output logic [NumCh-1:0]             zero_o,
    output logic [NumCh-1:0]             multi_o,
    output logic [ErrCntWidth-1:0]       err_cnt_o,
    input  logic                         err_clr_i
);

    localparam bit IsPrio = (PriorityMode == int'(OH_PRIORITY));

    logic [NumCh-1:0][OutputWidth-1:0] enc_idx;
    logic [NumCh-1:0]                  enc_zero;
    logic [NumCh-1:0]                  enc_multi;
    logic [NumCh-1:0][OutputWidth-1:0] idx_q;
    logic                              valid_q;
    logic [ErrCntWidth-1:0]            cnt_q;
    logic                              accept;
    logic                              beat_err;

    for (genvar c = 0; c < NumCh; c++) begin : g_lane
        oh_encode_lane #(
            .InputWidth  (InputWidth),
            .PriorityMode(PriorityMode)
        ) u_lane (
            .oh   (oh_i[c*InputWidth +: InputWidth]),
            .idx  (enc_idx[c]),
            .zero (enc_zero[c]),
            .multi(enc_multi[c])
        );
    end

    assign ready_o  = !valid_q || ready_i;
    assign accept   = valid_i && ready_o;
    // Multi-hot is legal input in priority mode; only zero lanes count there.
    assign beat_err = (|enc_zero) || (!IsPrio && (|enc_multi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            zero_o  <= '0;
            multi_o <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                idx_q   <= enc_idx;
                zero_o  <= enc_zero;
                multi_o <= enc_multi;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end

            if (err_clr_i) begin
                cnt_q <= '0;
            end else if (accept && beat_err && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign valid_o   = valid_q;
    assign idx_o     = idx_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_oh_encode_pipe.sv
// Directed bench: strict (W8,N2), priority (W8,N1,2-bit counter) and W1 instances.
module tb_oh_encode_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ready_i = 1'b1;
    logic clr = 1'b0;

    logic        va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic [15:0] oh_a = '0;
    logic [7:0]  oh_b = '0;
    logic [0:0]  oh_c = '0;

    logic       rdy_a, rdy_b, rdy_c;
    logic       vo_a, vo_b, vo_c;
    logic [5:0] idx_a;
    logic [2:0] idx_b;
    logic [0:0] idx_c;
    logic [1:0] z_a, m_a;
    logic [0:0] z_b, m_b, z_c, m_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    oh_encode_pipe #(.InputWidth(8), .NumCh(2), .PriorityMode(0), .ErrCntWidth(8)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(va), .ready_o(rdy_a), .oh_i(oh_a),
        .valid_o(vo_a), .ready_i(ready_i), .idx_o(idx_a), .zero_o(z_a), .multi_o(m_a),
        .err_cnt_o(cnt_a), .err_clr_i(clr)
    );

    oh_encode_pipe #(.InputWidth(8), .NumCh(1), .PriorityMode(1), .ErrCntWidth(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vb), .ready_o(rdy_b), .oh_i(oh_b),
        .valid_o(vo_b), .ready_i(ready_i), .idx_o(idx_b), .zero_o(z_b), .multi_o(m_b),
        .err_cnt_o(cnt_b), .err_clr_i(clr)
    );

    oh_encode_pipe #(.InputWidth(1), .NumCh(1), .PriorityMode(0), .ErrCntWidth(8)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vc), .ready_o(rdy_c), .oh_i(oh_c),
        .valid_o(vo_c), .ready_i(ready_i), .idx_o(idx_c), .zero_o(z_c), .multi_o(m_c),
        .err_cnt_o(cnt_c), .err_clr_i(clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are changed and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_valid", 32'(vo_a), 32'd0);
        chk("rst_idx", 32'(idx_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // basic encode
        va = 1'b1; oh_a = {8'h10, 8'h02};
        step();
        chk("b2b_valid", 32'(vo_a), 32'd1);
        chk("basic_idx", 32'(idx_a), 32'h21);
        chk("basic_zero", 32'(z_a), 32'd0);
        chk("basic_multi", 32'(m_a), 32'd0);
        chk("basic_cnt", 32'(cnt_a), 32'd0);

        // stall with a new beat waiting upstream
        ready_i = 1'b0; oh_a = {8'h01, 8'h80};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", 32'(rdy_a), 32'd0);
            chk("stall_valid", 32'(vo_a), 32'd1);
            chk("stall_idx", 32'(idx_a), 32'h21);
        end
        ready_i = 1'b1;
        step();
        chk("unstall_idx", 32'(idx_a), 32'h07);
        chk("unstall_valid", 32'(vo_a), 32'd1);
        va = 1'b0;
        step();
        chk("drain_valid", 32'(vo_a), 32'd0);

        // strict multi-hot lane 0C
        va = 1'b1; oh_a = {8'h0C, 8'h01};
        step();
        chk("strict_idx", 32'(idx_a), 32'h18);
        chk("strict_multi", 32'(m_a), 32'd2);
        chk("strict_cnt", 32'(cnt_a), 32'd1);

        // zero lane
        oh_a = {8'h00, 8'h04};
        step();
        chk("zero_idx", 32'(idx_a), 32'h02);
        chk("zero_flag", 32'(z_a), 32'd2);
        chk("zero_cnt", 32'(cnt_a), 32'd2);

        // clear wins over an erroneous accept at count 2
        oh_a = {8'h00, 8'h00}; clr = 1'b1;
        step();
        clr = 1'b0; va = 1'b0;
        chk("clr_cnt", 32'(cnt_a), 32'd0);
        chk("clr_zero", 32'(z_a), 32'd3);

        // priority mode: multi-hot legal, lowest bit wins
        vb = 1'b1; oh_b = 8'h0C;
        step();
        chk("prio_idx", 32'(idx_b), 32'd2);
        chk("prio_multi", 32'(m_b), 32'd1);
        chk("prio_cnt", 32'(cnt_b), 32'd0);

        // five zero beats saturate the 2-bit counter
        oh_b = 8'h00;
        step();
        chk("prio_zero_idx", 32'(idx_b), 32'd0);
        chk("prio_zero_flag", 32'(z_b), 32'd1);
        step();
        chk("sat_cnt2", 32'(cnt_b), 32'd2);
        step(); step(); step();
        chk("sat_cnt5", 32'(cnt_b), 32'd3);
        vb = 1'b0;

        // single-bit lanes
        vc = 1'b1; oh_c = 1'b1;
        step();
        chk("w1_idx", 32'(idx_c), 32'd0);
        chk("w1_multi", 32'(m_c), 32'd0);
        chk("w1_cnt", 32'(cnt_c), 32'd0);
        oh_c = 1'b0;
        step();
        chk("w1_zero", 32'(z_c), 32'd1);
        chk("w1_zero_cnt", 32'(cnt_c), 32'd1);
        vc = 1'b0;

        // async reset in the middle of a stall
        va = 1'b1; oh_a = {8'h00, 8'h40};
        step();
        va = 1'b0; ready_i = 1'b0;
        step();
        chk("pre_rst_idx", 32'(idx_a), 32'h06);
        chk("pre_rst_cnt", 32'(cnt_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(vo_a), 32'd0);
        chk("arst_idx", 32'(idx_a), 32'd0);
        chk("arst_zero", 32'(z_a), 32'd0);
        chk("arst_cnt", 32'(cnt_a), 32'd0);
        chk("arst_ready", 32'(rdy_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(vo_a), 32'd0);
        va = 1'b1; oh_a = {8'h20, 8'h08};
        step();
        va = 1'b0;
        chk("post_rst_idx", 32'(idx_a), 32'h2B);
        chk("post_rst_vld", 32'(vo_a), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
